parity_accumulator: RTL and testbench
=====================================

Name: parity_accumulator

Overview:
- Parametrised, sequential successor to the fixed 3-input XNOR gate.
- Reduces a WIDTH-bit input word, or a multi-beat frame of words, to a single XOR (even-parity) or XNOR result.
- Inputs and outputs use valid/ready handshakes, and the result is registered.
- Sits between a word-stream producer and a checker/consumer; the 3-input XNOR case is WIDTH=3, one beat, mode=1.

Parameters:
WIDTH, 8, bits per input word (>=1)
MAX_BEATS, 16, maximum beats per frame before forced close (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer presents a beat
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  beat data
in_last  input  1  beat closes the frame
mode  input  1  0 = XOR (even parity), 1 = XNOR; sampled on the first beat of a frame
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_result  output  1  frame reduction result
out_beats  output  $clog2(MAX_BEATS+1)  number of beats in the reported frame
out_overflow  output  1  frame was force-closed at MAX_BEATS without in_last

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_result=0, out_beats=0, out_overflow=0.
  - Internal accumulator=0, beat counter=0, latched mode=0.
- Handshakes:
  - Input beat accepted when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - While out_valid=1, out_result, out_beats and out_overflow stay stable until consumed.
- IDLE (in_ready=1):
  - On accept: latch mode, acc <= ^in_data, cnt <= 1.
  - If in_last=1 or MAX_BEATS==1: go to HOLD; else go to ACCUM.
- ACCUM (in_ready=1):
  - On accept: acc <= acc ^ (^in_data), cnt <= cnt+1.
  - If in_last=1: go to HOLD with overflow=0.
  - Else if cnt+1 == MAX_BEATS: go to HOLD with overflow=1.
  - The mode input is ignored in this state.
- HOLD (in_ready=0, out_valid=1):
  - out_result = final_acc ^ latched_mode.
  - out_beats = final count; out_overflow as determined on entry.
  - When out_ready=1: go to IDLE next cycle and clear acc/cnt.
  - No same-cycle bypass: at most one frame per (beats+1) cycles.
- Latency: out_valid rises on the cycle after the closing beat is accepted.
- Boundary cases:
  - No valid beat: state holds.
  - in_last together with the MAX_BEATS-th beat: normal close, overflow=0.
  - in_last with in_valid=0: ignored.
  - reset asserted mid-frame or in HOLD: the pending frame is discarded and the result is never presented.
  - out_ready asserted while out_valid=0: no effect.
  - in_data contains X/Z: not defined; the bench drives only known values.

Decomposition:
- Package parity_pkg:
  - State enum typedef {IDLE, ACCUM, HOLD}.
  - Mode constants MODE_XOR=1'b0, MODE_XNOR=1'b1.
- Sub-module parity_reduce:
  - Combinational, parameter WIDTH, input d[WIDTH], output p = ^d.
  - Instantiated once for the per-beat reduction.
- Remaining FSM, counter and output registers live in parity_accumulator.

Test Plan:
1. WIDTH=3, mode=1, single beat with last, sweep in_data 3'b000..3'b111 with out_ready=1 -> out_result = 1,0,0,1,0,1,1,0; out_beats=1; out_overflow=0; out_valid one cycle after each accept.
2. WIDTH=8, mode=0, frame 8'hFF, 8'h01, 8'h03(last) -> out_result=1, out_beats=3. Same frame with mode=1 -> out_result=0.
3. MAX_BEATS=4, mode=0, five beats of 8'h01 with in_last=0 -> after beat 4: out_valid=1, out_result=0, out_beats=4, out_overflow=1, in_ready=0; beat 5 is not accepted until the result is consumed.
4. Backpressure: hold out_ready=0 for 6 cycles after a result -> out_valid, out_result, out_beats stable and in_ready=0 for all 6 cycles; with out_ready=1, the next cycle gives IDLE and in_ready=1.
5. Change mode mid-frame (first beat mode=1, later beats mode=0), frame 8'h00, 8'h00(last) -> out_result=1 (latched XNOR).
6. Assert reset for 1 cycle in ACCUM after 2 beats, then send single beat 8'h01 last, mode=0 -> no stale result; out_result=1, out_beats=1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types for the parity accumulator.
// States and reduction-mode encodings.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic MODE_XOR  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

endpackage

// File: rtl/parity_reduce.sv
// Per-beat reduction of one input word.
// Pure combinational XOR tree.
module parity_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  output logic             p
);

  assign p = ^d;

endmodule

// File: rtl/parity_accumulator.sv
// Multi-beat XOR/XNOR reducer with valid/ready on both sides.
// Result is registered and held until the consumer takes it.
module parity_accumulator
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [CW-1:0]    out_beats,
  output logic             out_overflow
);

  state_t        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          res_q, res_d;
  logic [CW-1:0] beats_q, beats_d;
  logic          ovf_q, ovf_d;

  logic          beat_p;
  logic          acc_n;
  logic [CW-1:0] cnt_inc;

  parity_reduce #(
    .WIDTH(WIDTH)
  ) u_reduce (
    .d(in_data),
    .p(beat_p)
  );

  assign acc_n   = acc_q ^ beat_p;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    res_d   = res_q;
    beats_d = beats_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d = mode;
          acc_d  = beat_p;
          cnt_d  = CW'(1);
          if (in_last || MAX_BEATS == 1) begin
            state_d = HOLD;
            res_d   = beat_p ^ mode;
            beats_d = CW'(1);
            ovf_d   = ~in_last;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_n;
          cnt_d = cnt_inc;
          // in_last wins over the beat limit
          if (in_last || cnt_inc == CW'(MAX_BEATS)) begin
            state_d = HOLD;
            res_d   = acc_n ^ mode_q;
            beats_d = cnt_inc;
            ovf_d   = ~in_last;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = 1'b0;
          cnt_d   = '0;
          res_d   = 1'b0;
          beats_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_XOR;
      res_q   <= 1'b0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      beats_q <= beats_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready     = (state_q != HOLD);
  assign out_valid    = (state_q == HOLD);
  assign out_result   = res_q;
  assign out_beats    = beats_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_parity_accumulator.sv
// Directed bench: a 3-bit/16-beat instance and an 8-bit/4-beat instance.
// Expected values are hand-computed constants.
module tb_parity_accumulator;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [2:0] a_in_data = '0;
  logic       a_in_last = 1'b0;
  logic       a_mode = 1'b0;
  logic       a_out_valid;
  logic       a_out_ready = 1'b0;
  logic       a_out_result;
  logic [4:0] a_out_beats;
  logic       a_out_overflow;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_in_data = '0;
  logic       b_in_last = 1'b0;
  logic       b_mode = 1'b0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  logic       b_out_result;
  logic [2:0] b_out_beats;
  logic       b_out_overflow;

  parity_accumulator #(
    .WIDTH(3),
    .MAX_BEATS(16)
  ) dut_a (
    .clk(clk),
    .reset(reset),
    .in_valid(a_in_valid),
    .in_ready(a_in_ready),
    .in_data(a_in_data),
    .in_last(a_in_last),
    .mode(a_mode),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_result(a_out_result),
    .out_beats(a_out_beats),
    .out_overflow(a_out_overflow)
  );

  parity_accumulator #(
    .WIDTH(8),
    .MAX_BEATS(4)
  ) dut_b (
    .clk(clk),
    .reset(reset),
    .in_valid(b_in_valid),
    .in_ready(b_in_ready),
    .in_data(b_in_data),
    .in_last(b_in_last),
    .mode(b_mode),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_result(b_out_result),
    .out_beats(b_out_beats),
    .out_overflow(b_out_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [7:0] d, input logic last,
                        input logic m);
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_last  = last;
    b_mode     = m;
    tick();
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  task automatic chk_b(input string tag, input logic res,
                       input logic [2:0] beats, input logic ovf);
    chk({tag, "_valid"}, 32'(b_out_valid), 32'd1);
    chk({tag, "_ready"}, 32'(b_in_ready), 32'd0);
    chk({tag, "_res"}, 32'(b_out_result), 32'(res));
    chk({tag, "_beats"}, 32'(b_out_beats), 32'(beats));
    chk({tag, "_ovf"}, 32'(b_out_overflow), 32'(ovf));
  endtask

  task automatic consume_b(input string tag);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    tick();
    chk({tag, "_done"}, 32'(b_out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(b_in_ready), 32'd1);
  endtask

  logic [7:0] xnor3_tab;

  initial begin
    xnor3_tab = 8'h69;

    reset = 1'b1;
    tick();
    tick();
    chk("rst_a_ready", 32'(a_in_ready), 32'd1);
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_res", 32'(a_out_result), 32'd0);
    chk("rst_a_beats", 32'(a_out_beats), 32'd0);
    chk("rst_a_ovf", 32'(a_out_overflow), 32'd0);
    chk("rst_b_ready", 32'(b_in_ready), 32'd1);
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);
    chk("rst_b_beats", 32'(b_out_beats), 32'd0);
    reset = 1'b0;
    tick();

    // 3-input XNOR sweep
    a_out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      a_in_valid = 1'b1;
      a_in_data  = 3'(v);
      a_in_last  = 1'b1;
      a_mode     = 1'b1;
      tick();
      chk("x3_valid", 32'(a_out_valid), 32'd1);
      chk("x3_ready", 32'(a_in_ready), 32'd0);
      chk("x3_res", 32'(a_out_result), 32'(xnor3_tab[v]));
      chk("x3_beats", 32'(a_out_beats), 32'd1);
      chk("x3_ovf", 32'(a_out_overflow), 32'd0);
      a_in_valid = 1'b0;
      tick();
      chk("x3_done", 32'(a_out_valid), 32'd0);
    end

    // out_ready with nothing pending
    b_out_ready = 1'b1;
    tick();
    chk("nop_valid", 32'(b_out_valid), 32'd0);
    chk("nop_ready", 32'(b_in_ready), 32'd1);

    // three-beat frame, XOR then XNOR
    send_b(8'hFF, 1'b0, 1'b0);
    send_b(8'h01, 1'b0, 1'b0);
    chk("f3_mid", 32'(b_out_valid), 32'd0);
    send_b(8'h03, 1'b1, 1'b0);
    chk_b("f3_xor", 1'b1, 3'd3, 1'b0);
    consume_b("f3_xor");
    send_b(8'hFF, 1'b0, 1'b1);
    send_b(8'h01, 1'b0, 1'b1);
    send_b(8'h03, 1'b1, 1'b1);
    chk_b("f3_xnor", 1'b0, 3'd3, 1'b0);
    consume_b("f3_xnor");

    // forced close at MAX_BEATS, then backpressure
    b_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_b(8'h01, 1'b0, 1'b0);
    chk_b("ovf", 1'b0, 3'd4, 1'b1);
    b_in_valid = 1'b1;
    b_in_data  = 8'h01;
    b_in_last  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_b("bp", 1'b0, 3'd4, 1'b1);
    end
    b_out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(b_out_valid), 32'd0);
    chk("bp_rel_ready", 32'(b_in_ready), 32'd1);
    tick();
    chk_b("beat5", 1'b1, 3'd1, 1'b0);
    consume_b("beat5");

    // last on the MAX_BEATS-th beat is a normal close
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_b(8'h01, 1'b0, 1'b0);
    send_b(8'h01, 1'b1, 1'b0);
    chk_b("last4", 1'b0, 3'd4, 1'b0);
    consume_b("last4");

    // in_last without in_valid is ignored
    b_in_last = 1'b1;
    tick();
    chk("lastnv", 32'(b_out_valid), 32'd0);
    b_in_last = 1'b0;

    // mode latched on first beat
    send_b(8'h00, 1'b0, 1'b1);
    send_b(8'h00, 1'b1, 1'b0);
    chk_b("mode", 1'b1, 3'd2, 1'b0);
    consume_b("mode");

    // reset mid-frame discards it
    send_b(8'h01, 1'b0, 1'b0);
    send_b(8'h01, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", 32'(b_out_valid), 32'd0);
    chk("mrst_ready", 32'(b_in_ready), 32'd1);
    tick();
    chk("mrst_stale", 32'(b_out_valid), 32'd0);
    send_b(8'h01, 1'b1, 1'b0);
    chk_b("mrst", 1'b1, 3'd1, 1'b0);
    consume_b("mrst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
